// File: rtl/matrix_scan_pkg.sv
// Shared types and helpers for the LED matrix scan controller.
// Mode encoding and the index-width function used by ports and counters.
package matrix_scan_pkg;

  typedef enum logic {
    MODE_WALK = 1'b0,
    MODE_DISP = 1'b1
  } mode_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_scanner_onehot_dec.sv
// Index to one-hot decoder; all-zero when disabled.
// An index at or beyond N shifts out and also yields all-zero.
module onehot_dec
  import matrix_scan_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [idx_w(N)-1:0] idx,
  input  logic                en,
  output logic [N-1:0]        onehot
);

  // Shift a single set bit into position when enabled
  always_comb begin
    onehot = '0;
    if (en) onehot = N'(1) << idx;
  end

endmodule

// File: rtl/matrix_scanner.sv
// ROWSxCOLS LED matrix scanner: dot-walk or double-buffered display.
// All outputs are registered from next-state on the index edge.
module matrix_scanner
  import matrix_scan_pkg::*;
#(
  parameter int ROWS       = 5,
  parameter int COLS       = 7,
  parameter int STEP_DIV   = 8388608,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                   CLOCK_50,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   wr_en,
  input  logic [idx_w(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]        wr_data,
  input  logic                   commit,
  output logic                   commit_pending,
  output logic                   frame_start,
  output logic [ROWS-1:0]        row,
  output logic [COLS-1:0]        column
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);
  localparam int DMAX = (STEP_DIV > SCAN_DIV) ? STEP_DIV : SCAN_DIV;
  localparam int PW = idx_w(DMAX);

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [PW-1:0] STEP_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

  localparam logic [ROWS-1:0] ROW_POL = ACTIVE_LOW ? '1 : '0;
  localparam logic [COLS-1:0] COL_POL = ACTIVE_LOW ? '1 : '0;

  logic [PW-1:0]   pc;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   col_idx;
  logic            en_q;
  mode_e           mode_q;
  logic [COLS-1:0] shadow [ROWS];
  logic [COLS-1:0] front  [ROWS];

  logic [PW-1:0]   pc_last;
  logic [PW-1:0]   pc_nxt;
  logic [RW-1:0]   row_ok;
  logic [RW-1:0]   row_nxt;
  logic [CW-1:0]   col_ok;
  logic [CW-1:0]   col_nxt;
  logic            restart;
  logic            tick;
  logic            boundary;
  logic            copy;
  logic            pend_nxt;
  logic            fs_nxt;
  logic            walk_en;
  logic [ROWS-1:0] row_oh;
  logic [COLS-1:0] col_oh;
  logic [COLS-1:0] disp_col;
  logic [COLS-1:0] col_out;

  // Next-state for prescaler, scan indices, frame boundary and commit
  always_comb begin
    pc_last  = (mode == MODE_DISP) ? SCAN_LAST : STEP_LAST;
    restart  = en && (!en_q || (mode_e'(mode) != mode_q));
    row_ok   = (row_idx > ROW_LAST) ? '0 : row_idx;
    col_ok   = (col_idx > COL_LAST) ? '0 : col_idx;
    tick     = en && !restart && (pc == pc_last);
    pc_nxt   = '0;
    row_nxt  = row_ok;
    col_nxt  = col_ok;
    boundary = 1'b0;
    if (en && !restart && (pc < pc_last)) pc_nxt = pc + 1'b1;
    if (!en || restart) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if (mode == MODE_DISP) begin
      col_nxt = '0;
      if (tick) begin
        if (row_ok == ROW_LAST) begin
          row_nxt  = '0;
          boundary = 1'b1;
        end else begin
          row_nxt = row_ok + 1'b1;
        end
      end
    end else if (tick) begin
      if (col_ok == COL_LAST) begin
        col_nxt = '0;
        if (row_ok == ROW_LAST) begin
          row_nxt  = '0;
          boundary = 1'b1;
        end else begin
          row_nxt = row_ok + 1'b1;
        end
      end else begin
        col_nxt = col_ok + 1'b1;
      end
    end
    copy     = (commit_pending || commit) && (boundary || !en);
    pend_nxt = (commit_pending || commit) && !copy;
    fs_nxt   = restart || boundary;
  end

  assign walk_en = en && (mode == MODE_WALK);

  onehot_dec #(.N(ROWS)) u_row_dec (
    .idx    (row_nxt),
    .en     (en),
    .onehot (row_oh)
  );

  onehot_dec #(.N(COLS)) u_col_dec (
    .idx    (col_nxt),
    .en     (walk_en),
    .onehot (col_oh)
  );

  // Display column comes from the front buffer as it will be after this edge
  always_comb begin
    disp_col = copy ? shadow[row_nxt] : front[row_nxt];
    col_out  = '0;
    if (walk_en) col_out = col_oh;
    else if (en) col_out = disp_col;
  end

  // Scan state, buffers and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pc             <= '0;
      row_idx        <= '0;
      col_idx        <= '0;
      en_q           <= 1'b0;
      mode_q         <= MODE_WALK;
      commit_pending <= 1'b0;
      frame_start    <= 1'b0;
      row            <= ROW_POL;
      column         <= COL_POL;
      for (int i = 0; i < ROWS; i++) begin
        shadow[i] <= '0;
        front[i]  <= '0;
      end
    end else begin
      pc             <= pc_nxt;
      row_idx        <= row_nxt;
      col_idx        <= col_nxt;
      en_q           <= en;
      mode_q         <= mode_e'(mode);
      commit_pending <= pend_nxt;
      frame_start    <= fs_nxt;
      row            <= row_oh ^ ROW_POL;
      column         <= col_out ^ COL_POL;
      if (copy) begin
        for (int i = 0; i < ROWS; i++) front[i] <= shadow[i];
      end
      if (wr_en && (wr_row <= ROW_LAST)) shadow[wr_row] <= wr_data;
    end
  end

endmodule
